// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: registered fetch program counter with next-PC generation.
//
// The PC advances by INC on every non-stalled cycle, holds while the I-cache
// stalls, and takes a redirect either at once (no stall) or from a one-entry
// pending buffer once the stall clears. A saturating counter records stalled
// cycles since reset.
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//   When defined, adds misalign_o. Redirect targets that are not a multiple of
//   INC are rejected and flagged with a one-cycle pulse on misalign_o.
//
// Ports:
//   clk                 clock, all state updates on rising edge
//   rst_n               asynchronous active-low reset
//   stall_i             fetch stall; PC holds
//   redirect_i          one-cycle redirect pulse
//   redirect_target_i   redirect target address
//   pc_o                current fetch PC (registered)
//   pc_plus_o           pc_o + INC, modulo 2^XLEN
//   fetch_valid_o       pc_o is a valid fetch request
//   redirect_pending_o  a redirect is buffered behind a stall
//   misalign_o          (PC_ALIGN_CHECK_EN only) rejected-redirect pulse
//   stall_cnt_o         saturating stalled-cycle count

module pc_fetch_unit #(
  parameter int unsigned            XLEN         = 32,
  parameter int unsigned            INC          = 4,
  parameter logic [XLEN-1:0]        RESET_VECTOR = '0,
  parameter int unsigned            STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall_i,
  input  logic                   redirect_i,
  input  logic [XLEN-1:0]        redirect_target_i,
  output logic [XLEN-1:0]        pc_o,
  output logic [XLEN-1:0]        pc_plus_o,
  output logic                   fetch_valid_o,
  output logic                   redirect_pending_o,
`ifdef PC_ALIGN_CHECK_EN
  output logic                   misalign_o,
`endif
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {StBoot, StRun, StStall} state_e;

  state_e                 r_state, w_state_d;
  logic [XLEN-1:0]        r_pc, w_pc_d;
  logic                   r_pend_vld, w_pend_vld_d;
  logic [XLEN-1:0]        r_pend_tgt, w_pend_tgt_d;
  logic [STALL_CNT_W-1:0] r_stall_cnt, w_stall_cnt_d;
  logic                   w_redir_ok;
  logic                   w_pc_plus_unused;

`ifdef PC_ALIGN_CHECK_EN
  logic r_misalign, w_misalign_d;
  logic w_aligned;

  assign w_aligned  = ((redirect_target_i % XLEN'(INC)) == '0);
  assign w_redir_ok = redirect_i & w_aligned;
`else
  assign w_redir_ok = redirect_i;
`endif

  assign w_pc_plus_unused = 1'b0;

  always_comb begin
    w_state_d     = r_state;
    w_pc_d        = r_pc;
    w_pend_vld_d  = r_pend_vld;
    w_pend_tgt_d  = r_pend_tgt;
    w_stall_cnt_d = r_stall_cnt;
`ifdef PC_ALIGN_CHECK_EN
    w_misalign_d  = 1'b0;
`endif
    unique case (r_state)
      // Boot cycle: PC already holds RESET_VECTOR, inputs are ignored.
      StBoot: w_state_d = StRun;
      StRun, StStall: begin
`ifdef PC_ALIGN_CHECK_EN
        w_misalign_d = redirect_i & ~w_aligned;
`endif
        if (stall_i) begin
          w_state_d = StStall;
          if (r_stall_cnt != '1) w_stall_cnt_d = r_stall_cnt + 1'b1;
          // Latest redirect during a stall overwrites any earlier one.
          if (w_redir_ok) begin
            w_pend_vld_d = 1'b1;
            w_pend_tgt_d = redirect_target_i;
          end
        end else begin
          w_state_d = StRun;
          if (w_redir_ok) begin
            w_pc_d       = redirect_target_i;
            w_pend_vld_d = 1'b0;
          end else if (r_pend_vld) begin
            w_pc_d       = r_pend_tgt;
            w_pend_vld_d = 1'b0;
          end else begin
            w_pc_d = r_pc + XLEN'(INC);
          end
        end
      end
      default: w_state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StBoot;
      r_pc        <= RESET_VECTOR;
      r_pend_vld  <= 1'b0;
      r_pend_tgt  <= '0;
      r_stall_cnt <= '0;
`ifdef PC_ALIGN_CHECK_EN
      r_misalign  <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_d;
      r_pc        <= w_pc_d;
      r_pend_vld  <= w_pend_vld_d;
      r_pend_tgt  <= w_pend_tgt_d;
      r_stall_cnt <= w_stall_cnt_d;
`ifdef PC_ALIGN_CHECK_EN
      r_misalign  <= w_misalign_d;
`endif
    end
  end

  assign pc_o               = r_pc;
  assign pc_plus_o          = r_pc + XLEN'(INC) + XLEN'(w_pc_plus_unused);
  assign fetch_valid_o      = (r_state != StBoot);
  assign redirect_pending_o = r_pend_vld;
  assign stall_cnt_o        = r_stall_cnt;
`ifdef PC_ALIGN_CHECK_EN
  assign misalign_o         = r_misalign;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit (XLEN=32, INC=4, RESET_VECTOR=0,
// STALL_CNT_W=4 so saturation is reachable quickly).
module tb_pc_fetch_unit;

  localparam int unsigned CW  = 4;
  localparam int          MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall_i, redirect_i;
  logic [31:0]   redirect_target_i;
  logic [31:0]   pc_o, pc_plus_o;
  logic          fetch_valid_o, redirect_pending_o;
  logic [CW-1:0] stall_cnt_o;
`ifdef PC_ALIGN_CHECK_EN
  logic          misalign_o;
`endif

  pc_fetch_unit #(
    .XLEN(32), .INC(4), .RESET_VECTOR(32'h0), .STALL_CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_target_i(redirect_target_i), .pc_o(pc_o), .pc_plus_o(pc_plus_o),
    .fetch_valid_o(fetch_valid_o), .redirect_pending_o(redirect_pending_o),
`ifdef PC_ALIGN_CHECK_EN
    .misalign_o(misalign_o),
`endif
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural state only.
  logic [31:0] m_pc, m_pend;
  bit          m_boot, m_pv, m_mis;
  int          m_cnt;

  task automatic model_reset();
    m_pc = 32'h0; m_pend = 32'h0; m_boot = 1; m_pv = 0; m_mis = 0; m_cnt = 0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, sample at +1.
  task automatic tick(input bit st, input bit rd, input logic [31:0] tgt);
    bit acc;
    stall_i = st; redirect_i = rd; redirect_target_i = tgt;
    @(posedge clk);
    acc = rd;
    m_mis = 0;
`ifdef PC_ALIGN_CHECK_EN
    if (!m_boot && rd && (tgt % 4 != 0)) begin acc = 0; m_mis = 1; end
`endif
    if (m_boot) m_boot = 0;
    else if (st) begin
      if (m_cnt < MAXC) m_cnt++;
      if (acc) begin m_pend = tgt; m_pv = 1; end
    end else if (acc) begin m_pc = tgt; m_pv = 0; end
    else if (m_pv) begin m_pc = m_pend; m_pv = 0; end
    else m_pc = m_pc + 32'd4;
    #1;
    stall_i = 0; redirect_i = 0; redirect_target_i = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 0; stall_i = 0; redirect_i = 0; redirect_target_i = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (pc_o !== 32'h0 || pc_plus_o !== 32'h4 || fetch_valid_o !== 1'b0 ||
        redirect_pending_o !== 1'b0 || stall_cnt_o !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: pc=%h plus=%h v=%b pend=%b cnt=%0d, want 0/4/0/0/0",
               pc_o, pc_plus_o, fetch_valid_o, redirect_pending_o, stall_cnt_o);
    end
    rst_n = 1;
    #1;
    n_checks++;
    if (fetch_valid_o !== 1'b0 || pc_o !== 32'h0) begin
      n_fail++;
      $display("FAIL boot_cycle: v=%b pc=%h, want v=0 pc=0", fetch_valid_o, pc_o);
    end
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 32'h0);
      n_checks++;
      if (pc_o !== 32'(i * 4) || fetch_valid_o !== 1'b1 || pc_plus_o !== 32'(i * 4 + 4)) begin
        n_fail++;
        $display("FAIL run_seq[%0d]: pc=%h plus=%h v=%b, want pc=%h v=1",
                 i, pc_o, pc_plus_o, fetch_valid_o, 32'(i * 4));
      end
    end
  endtask

  task automatic test_redirect();
    tick(0, 0, 32'h0);  // pc 0x10
    n_checks++;
    if (pc_o !== 32'h10) begin
      n_fail++; $display("FAIL pre_redirect: pc=%h, want 00000010", pc_o);
    end
    tick(0, 1, 32'h200);
    n_checks++;
    if (pc_o !== 32'h200) begin
      n_fail++; $display("FAIL redirect_now: pc=%h, want 00000200", pc_o);
    end
    tick(0, 0, 32'h0);
    n_checks++;
    if (pc_o !== 32'h204) begin
      n_fail++; $display("FAIL redirect_next: pc=%h, want 00000204", pc_o);
    end
  endtask

  task automatic test_stall_redirect();
    tick(0, 1, 32'h40);
    for (int c = 1; c <= 5; c++) begin
      tick(1, (c == 2 || c == 4), (c == 2) ? 32'h80 : 32'h90);
      n_checks++;
      if (pc_o !== 32'h40 || redirect_pending_o !== (c >= 2)) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: pc=%h pend=%b, want pc=40 pend=%b",
                 c, pc_o, redirect_pending_o, c >= 2);
      end
    end
    n_checks++;
    if (stall_cnt_o !== 4'd5) begin
      n_fail++; $display("FAIL stall_cnt5: cnt=%0d, want 5", stall_cnt_o);
    end
    tick(0, 0, 32'h0);
    n_checks++;
    if (pc_o !== 32'h90 || redirect_pending_o !== 1'b0) begin
      n_fail++; $display("FAIL pend_apply: pc=%h pend=%b, want 90/0", pc_o, redirect_pending_o);
    end
    tick(0, 0, 32'h0);
    n_checks++;
    if (pc_o !== 32'h94) begin
      n_fail++; $display("FAIL pend_next: pc=%h, want 00000094", pc_o);
    end
  endtask

  task automatic test_simultaneous();
    tick(1, 1, 32'h300);
    tick(0, 1, 32'h500);
    n_checks++;
    if (pc_o !== 32'h500 || redirect_pending_o !== 1'b0) begin
      n_fail++; $display("FAIL supersede: pc=%h pend=%b, want 500/0", pc_o, redirect_pending_o);
    end
    tick(0, 0, 32'h0);
    n_checks++;
    if (pc_o !== 32'h504) begin
      n_fail++; $display("FAIL supersede_next: pc=%h, want 00000504", pc_o);
    end
  endtask

  task automatic test_wrap_saturation();
    logic [31:0] exp_seq [3];
    exp_seq[0] = 32'hFFFF_FFF8; exp_seq[1] = 32'hFFFF_FFFC; exp_seq[2] = 32'h0;
    tick(0, 1, 32'hFFFF_FFF8);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick(0, 0, 32'h0);
      n_checks++;
      if (pc_o !== exp_seq[i]) begin
        n_fail++; $display("FAIL wrap[%0d]: pc=%h, want %h", i, pc_o, exp_seq[i]);
      end
    end
    repeat (20) tick(1, 0, 32'h0);
    n_checks++;
    if (stall_cnt_o !== 4'd15 || pc_o !== 32'h0) begin
      n_fail++; $display("FAIL saturate: cnt=%0d pc=%h, want 15/0", stall_cnt_o, pc_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      tick(($urandom_range(2) == 0), ($urandom_range(3) == 0), $urandom & 32'hFFFF_FFFC);
      n_checks++;
      if (pc_o !== m_pc || pc_plus_o !== m_pc + 32'd4 || fetch_valid_o !== !m_boot ||
          redirect_pending_o !== m_pv || stall_cnt_o !== CW'(m_cnt)) begin
        n_fail++;
        $display("FAIL random[%0d]: pc=%h pend=%b cnt=%0d, want pc=%h pend=%b cnt=%0d",
                 i, pc_o, redirect_pending_o, stall_cnt_o, m_pc, m_pv, m_cnt);
      end
    end
  endtask

  task automatic test_async_reset();
    tick(1, 1, 32'h700);
    #2 rst_n = 0;  // mid-cycle, away from any edge
    model_reset();
    #1;
    n_checks++;
    if (pc_o !== 32'h0 || fetch_valid_o !== 1'b0 || redirect_pending_o !== 1'b0 ||
        stall_cnt_o !== '0) begin
      n_fail++;
      $display("FAIL async_reset: pc=%h v=%b pend=%b cnt=%0d, want 0/0/0/0",
               pc_o, fetch_valid_o, redirect_pending_o, stall_cnt_o);
    end
    @(posedge clk); #1 rst_n = 1;
    tick(1, 1, 32'h40);  // boot cycle ignores both
    n_checks++;
    if (pc_o !== 32'h0 || fetch_valid_o !== 1'b1 || redirect_pending_o !== 1'b0 ||
        stall_cnt_o !== '0) begin
      n_fail++;
      $display("FAIL boot_ignore: pc=%h v=%b pend=%b cnt=%0d, want 0/1/0/0",
               pc_o, fetch_valid_o, redirect_pending_o, stall_cnt_o);
    end
  endtask

`ifdef PC_ALIGN_CHECK_EN
  task automatic test_misalign();
    logic [31:0] before;
    before = m_pc;
    tick(0, 1, 32'h102);
    n_checks++;
    if (pc_o !== before + 32'd4 || misalign_o !== 1'b1) begin
      n_fail++;
      $display("FAIL misalign_reject: pc=%h mis=%b, want %h/1", pc_o, misalign_o, before + 32'd4);
    end
    tick(0, 0, 32'h0);
    n_checks++;
    if (misalign_o !== 1'b0 || pc_o !== m_pc) begin
      n_fail++; $display("FAIL misalign_pulse: mis=%b pc=%h, want 0/%h", misalign_o, pc_o, m_pc);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_redirect();
    test_stall_redirect();
    test_simultaneous();
    test_wrap_saturation();
    test_random();
    test_async_reset();
`ifdef PC_ALIGN_CHECK_EN
    test_misalign();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
